// File: rtl/dfu_boot_ctrl.sv
// Boot-control block for TinyDFU tops: sequences the DFU core reset, chooses
// between staying in the bootloader and warm-booting the user image, and drives the status LED.
module dfu_boot_ctrl #(
    parameter int unsigned RESET_CYCLES   = 12000,
    parameter int unsigned BOOT_CYCLES    = 36000000,
    parameter logic [1:0]  BOOT_IMAGE     = 2'b01,
    parameter int unsigned LED_MSB        = 23,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_locked,
    input  logic [7:0] dfu_state,
    input  logic       usb_reset,
    input  logic       boot_req,
    output logic       core_reset,
    output logic       boot,
    output logic [1:0] boot_sel,
    output logic       bootloader_active,
    output logic       led
);

    localparam int unsigned TMAX = (RESET_CYCLES > BOOT_CYCLES) ? RESET_CYCLES : BOOT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RESET_LOAD = TW'(RESET_CYCLES);
    localparam logic [TW-1:0] BOOT_LOAD  = TW'(BOOT_CYCLES);

    typedef enum logic [1:0] {
        ST_RESET_HOLD,
        ST_WAIT_ENUM,
        ST_STAY,
        ST_BOOT
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          core_reset_q, boot_q, bl_active_q, led_q, led_d;
    logic          boot_now;
    logic [10:0]   cnt_q;
    logic          cnt_step;
    logic [4:0]    ramp;
    logic          idle, busy;

    // One timer serves both the reset hold and the enumeration window.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        boot_now = ((dfu_state == 8'h01) && usb_reset) || boot_req;
        if (clk_locked) begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (timer_q <= TW'(1)) begin
                        state_d = ST_WAIT_ENUM;
                        timer_d = BOOT_LOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                ST_WAIT_ENUM: begin
                    timer_d = timer_q - TW'(1);
                    if (boot_now) begin
                        state_d = ST_BOOT;
                    end else if (dfu_state != 8'h00) begin
                        state_d = ST_STAY;
                    end else if (timer_q <= TW'(1)) begin
                        state_d = ST_BOOT;
                    end
                end
                ST_STAY: begin
                    if (boot_now) begin
                        state_d = ST_BOOT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RESET_HOLD;
            timer_q      <= RESET_LOAD;
            core_reset_q <= 1'b1;
            boot_q       <= 1'b0;
            bl_active_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            core_reset_q <= (state_d == ST_RESET_HOLD);
            boot_q       <= (state_d == ST_BOOT);
            bl_active_q  <= (state_d == ST_STAY);
        end
    end

    // LED counter is split into a low prescaler and the 11 pattern bits;
    // together they count exactly like one LED_MSB+1 wide free-running counter.
    if (LED_MSB > 10) begin : g_pre
        logic [LED_MSB-11:0] pre_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
        assign cnt_step = &pre_q;
    end else begin : g_nopre
        assign cnt_step = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_step) begin
            cnt_q <= cnt_q + 11'd1;
        end
    end

    always_comb begin
        idle  = (cnt_q[9:7] == 3'd3) || (cnt_q[9:7] == 3'd5);
        ramp  = cnt_q[10] ? cnt_q[9:5] : (5'd31 - cnt_q[9:5]);
        busy  = (cnt_q[4:0] >= ramp);
        led_d = 1'b0;
        if ((state_q == ST_WAIT_ENUM) || (state_q == ST_STAY)) begin
            case (dfu_state)
                8'h00:   led_d = ~idle;
                8'h02:   led_d = idle;
                default: led_d = busy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign core_reset        = core_reset_q;
    assign boot              = boot_q;
    assign bootloader_active = bl_active_q;
    assign boot_sel          = BOOT_IMAGE;
    assign led               = led_q ^ LED_ACTIVE_LOW;

endmodule

// File: tb/tb_dfu_boot_ctrl.sv
// Directed bench for dfu_boot_ctrl with short timers and a fast LED counter.
module tb_dfu_boot_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clk_locked;
    logic [7:0] dfu_state;
    logic       usb_reset;
    logic       boot_req;
    logic       core_reset, boot, bootloader_active, led;
    logic [1:0] boot_sel;
    logic       core_reset2, boot2, bootloader_active2, led2;
    logic [1:0] boot_sel2;
    logic [10:0] m_cnt;

    int checks   = 0;
    int failures = 0;

    dfu_boot_ctrl #(
        .RESET_CYCLES(4), .BOOT_CYCLES(10), .BOOT_IMAGE(2'b01),
        .LED_MSB(10), .LED_ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .clk_locked(clk_locked), .dfu_state(dfu_state),
        .usb_reset(usb_reset), .boot_req(boot_req), .core_reset(core_reset), .boot(boot),
        .boot_sel(boot_sel), .bootloader_active(bootloader_active), .led(led)
    );

    dfu_boot_ctrl #(
        .RESET_CYCLES(4), .BOOT_CYCLES(10), .BOOT_IMAGE(2'b10),
        .LED_MSB(10), .LED_ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .clk(clk), .reset_n(reset_n), .clk_locked(clk_locked), .dfu_state(dfu_state),
        .usb_reset(usb_reset), .boot_req(boot_req), .core_reset(core_reset2), .boot(boot2),
        .boot_sel(boot_sel2), .bootloader_active(bootloader_active2), .led(led2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LED counter value (after the most recent edge).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_cnt <= '0;
        else          m_cnt <= m_cnt + 11'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic led_model(input logic [7:0] d, input logic [10:0] c);
        logic       idl;
        logic [4:0] r;
        idl = (c[9:7] == 3'd3) || (c[9:7] == 3'd5);
        r   = c[10] ? c[9:5] : (5'd31 - c[9:5]);
        case (d)
            8'h00:   return ~idl;
            8'h02:   return idl;
            default: return (c[4:0] >= r);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        clk_locked = 1'b1;
        dfu_state  = 8'h00;
        usb_reset  = 1'b0;
        boot_req   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        clk_locked = 1'b1;
        dfu_state  = 8'h02;
        usb_reset  = 1'b1;
        boot_req   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
        checks++; if (boot !== 1'b0) begin failures++; $display("FAIL reset_boot got=%b exp=0", boot); end
        checks++; if (bootloader_active !== 1'b0) begin failures++; $display("FAIL reset_bl_active got=%b exp=0", bootloader_active); end
        checks++; if (boot_sel !== 2'b01) begin failures++; $display("FAIL reset_boot_sel got=%b exp=01", boot_sel); end
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", led); end
        checks++; if (led2 !== 1'b1) begin failures++; $display("FAIL reset_led_active_low got=%b exp=1", led2); end
        checks++; if (boot_sel2 !== 2'b10) begin failures++; $display("FAIL reset_boot_sel_img2 got=%b exp=10", boot_sel2); end
    endtask

    task automatic test_boot_timeout();
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++; if (core_reset !== (e < 4)) begin failures++; $display("FAIL timeout_core_reset edge=%0d got=%b exp=%b", e, core_reset, (e < 4)); end
            checks++; if (boot !== (e >= 14)) begin failures++; $display("FAIL timeout_boot edge=%0d got=%b exp=%b", e, boot, (e >= 14)); end
            if (e <= 4) begin
                checks++; if (led !== 1'b0) begin failures++; $display("FAIL timeout_led_off edge=%0d got=%b exp=0", e, led); end
            end
        end
    endtask

    task automatic test_lock_pause();
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            clk_locked = !((e >= 2) && (e <= 6));
            tick();
            checks++; if (core_reset !== (e < 9)) begin failures++; $display("FAIL lock_core_reset edge=%0d got=%b exp=%b", e, core_reset, (e < 9)); end
            checks++; if (boot !== (e >= 19)) begin failures++; $display("FAIL lock_boot edge=%0d got=%b exp=%b", e, boot, (e >= 19)); end
        end
        clk_locked = 1'b1;
    endtask

    task automatic test_stay_latch();
        int bad;
        do_reset();
        repeat (6) tick();
        checks++; if (bootloader_active !== 1'b0) begin failures++; $display("FAIL stay_before got=%b exp=0", bootloader_active); end
        dfu_state = 8'h02;
        tick();
        checks++; if (bootloader_active !== 1'b1) begin failures++; $display("FAIL stay_enter got=%b exp=1", bootloader_active); end
        dfu_state = 8'h00;
        bad = 0;
        repeat (120) begin
            tick();
            if ((bootloader_active !== 1'b1) || (boot !== 1'b0)) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stay_hold bad_cycles got=%0d exp=0", bad); end
        dfu_state = 8'h01;
        tick();
        checks++; if ({boot, bootloader_active} !== 2'b01) begin failures++; $display("FAIL stay_detach_no_usbrst got=%b exp=01", {boot, bootloader_active}); end
        dfu_state = 8'h02;
        usb_reset = 1'b1;
        tick();
        usb_reset = 1'b0;
        tick();
        checks++; if ({boot, bootloader_active} !== 2'b01) begin failures++; $display("FAIL stay_usbrst_idle got=%b exp=01", {boot, bootloader_active}); end
        dfu_state = 8'h01;
        usb_reset = 1'b1;
        tick();
        usb_reset = 1'b0;
        dfu_state = 8'h00;
        checks++; if ({boot, bootloader_active} !== 2'b10) begin failures++; $display("FAIL stay_detach_boot got=%b exp=10", {boot, bootloader_active}); end
        bad = 0;
        repeat (8) begin
            tick();
            if ((boot !== 1'b1) || (core_reset !== 1'b0)) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL boot_held bad_cycles got=%0d exp=0", bad); end
        reset_n = 1'b0;
        #2;
        checks++; if ({core_reset, boot} !== 2'b10) begin failures++; $display("FAIL boot_reset_exit got=%b exp=10", {core_reset, boot}); end
    endtask

    task automatic test_timer_tie();
        do_reset();
        repeat (13) tick();
        checks++; if ({boot, bootloader_active} !== 2'b00) begin failures++; $display("FAIL tie_pre got=%b exp=00", {boot, bootloader_active}); end
        dfu_state = 8'h05;
        tick();
        checks++; if ({boot, bootloader_active} !== 2'b01) begin failures++; $display("FAIL tie_edge got=%b exp=01", {boot, bootloader_active}); end
        dfu_state = 8'h00;
        repeat (10) tick();
        checks++; if ({boot, bootloader_active} !== 2'b01) begin failures++; $display("FAIL tie_after got=%b exp=01", {boot, bootloader_active}); end
    endtask

    task automatic test_boot_req();
        do_reset();
        tick();
        boot_req = 1'b1;
        dfu_state = 8'h01;
        usb_reset = 1'b1;
        tick();
        boot_req = 1'b0;
        dfu_state = 8'h00;
        usb_reset = 1'b0;
        checks++; if ({core_reset, boot} !== 2'b10) begin failures++; $display("FAIL hold_ignores_inputs got=%b exp=10", {core_reset, boot}); end
        repeat (2) tick();
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL hold_count_intact got=%b exp=0", core_reset); end
        dfu_state = 8'h02;
        boot_req  = 1'b1;
        tick();
        boot_req  = 1'b0;
        checks++; if ({boot, bootloader_active} !== 2'b10) begin failures++; $display("FAIL wait_bootreq_prio got=%b exp=10", {boot, bootloader_active}); end

        do_reset();
        repeat (4) tick();
        dfu_state = 8'h01;
        usb_reset = 1'b1;
        tick();
        usb_reset = 1'b0;
        dfu_state = 8'h00;
        checks++; if ({boot, bootloader_active} !== 2'b10) begin failures++; $display("FAIL wait_detach_prio got=%b exp=10", {boot, bootloader_active}); end

        do_reset();
        repeat (4) tick();
        dfu_state = 8'h02;
        tick();
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        checks++; if ({boot, bootloader_active} !== 2'b10) begin failures++; $display("FAIL stay_bootreq got=%b exp=10", {boot, bootloader_active}); end
        reset_n = 1'b0;
        #2;
        checks++; if ({core_reset, boot, bootloader_active} !== 3'b100) begin failures++; $display("FAIL bootreq_reset_exit got=%b exp=100", {core_reset, boot, bootloader_active}); end
    endtask

    task automatic led_window(input logic [7:0] d, input int n, input int exp_ones, input string name);
        int bad;
        int ones;
        logic e;
        bad  = 0;
        ones = 0;
        dfu_state = d;
        for (int i = 0; i < n; i++) begin
            tick();
            e = led_model(d, m_cnt - 11'd1);
            if ((led !== e) || (led2 !== ~e)) bad++;
            if (led === 1'b1) ones++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL %s pattern bad_cycles got=%0d exp=0", name, bad); end
        checks++; if (ones !== exp_ones) begin failures++; $display("FAIL %s duty ones got=%0d exp=%0d", name, ones, exp_ones); end
    endtask

    task automatic test_led();
        do_reset();
        repeat (4) tick();
        dfu_state = 8'h02;
        repeat (2) tick();
        // 0x02: index 3 and 5 of 8 lit -> 256 of 1024
        led_window(8'h02, 1024, 256, "led_dfuidle");
        led_window(8'h00, 1024, 768, "led_appidle");
        // busy: each of 64 ramp segments lights 32-ramp cycles -> 2*(1024-496)
        led_window(8'h05, 2048, 1056, "led_busy");
        checks++; if (bootloader_active !== 1'b1) begin failures++; $display("FAIL led_state_stay got=%b exp=1", bootloader_active); end
    endtask

    initial begin
        reset_n    = 1'b0;
        clk_locked = 1'b1;
        dfu_state  = 8'h00;
        usb_reset  = 1'b0;
        boot_req   = 1'b0;
        test_reset();
        test_boot_timeout();
        test_lock_pause();
        test_stay_latch();
        test_timer_tie();
        test_boot_req();
        test_led();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dfu_boot_ctrl.md
# dfu_boot_ctrl

Parametrised boot-control block for TinyDFU board tops. It replaces the per-board reset-delay, boot-timeout, user-bootmode latch and LED-pattern logic with one reusable block. It sequences the USB DFU core reset, decides between staying in the bootloader and warm-booting the user image, and drives the status LED from the DFU state. It sits between the PLL/lock logic, `usb_dfu_core` and the `SB_WARMBOOT` primitive.

## Interface
- `RESET_CYCLES`, 12000: locked clock edges that `core_reset` is held after `reset_n` release (≥1).
- `BOOT_CYCLES`, 36000000: locked clock edges allowed for enumeration before the user image boots (≥1).
- `BOOT_IMAGE`, 2'b01: warmboot image index driven on `boot_sel`.
- `LED_MSB`, 23: MSB of the LED pattern counter (≥10); sets pattern speed.
- `LED_ACTIVE_LOW`, 0: 1 inverts the `led` output.

- `clk` in 1: block clock (12 MHz on current boards).
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_locked` in 1: PLL lock; all timers advance only when high.
- `dfu_state` in 8: DFU state from the core (0x00 appIDLE, 0x01 appDETACH, 0x02 dfuIDLE, others busy).
- `usb_reset` in 1: USB bus reset from the PHY, synchronous to `clk`.
- `boot_req` in 1: single-cycle request to boot the user image now.
- `core_reset` out 1: active-high reset to the DFU core.
- `boot` out 1: to `SB_WARMBOOT.BOOT`; held once asserted.
- `boot_sel` out 2: to `SB_WARMBOOT.S1/S0`; constant `BOOT_IMAGE`.
- `bootloader_active` out 1: high while latched in the bootloader.
- `led` out 1: status LED.

## Operation
- FSM states: RESET_HOLD, WAIT_ENUM, STAY, BOOT. Reset enters RESET_HOLD from any state, including BOOT.
- RESET_HOLD:
  - A down-counter loads `RESET_CYCLES` and decrements on each locked edge.
  - The edge where it reaches 0 enters WAIT_ENUM and loads the boot timer with `BOOT_CYCLES`.
  - `dfu_state`, `usb_reset` and `boot_req` are ignored in this state.
- WAIT_ENUM: the boot timer decrements on each locked edge. Priority, highest first:
  1. `dfu_state`==0x01 with `usb_reset` high, or `boot_req` high: go to BOOT.
  2. `dfu_state`≠0x00: go to STAY (enumeration beats a simultaneous timer expiry).
  3. Timer reaches 0: go to BOOT.
- STAY is latched:
  - A return of `dfu_state` to 0x00 does not leave STAY.
  - Exit to BOOT only on (`dfu_state`==0x01 and `usb_reset`) or `boot_req`.
- BOOT is terminal until `reset_n`.
- Registered outputs, all from state:
  - `core_reset` = (state==RESET_HOLD).
  - `boot` = (state==BOOT).
  - `bootloader_active` = (state==STAY).
- LED counter:
  - Free-running, width `LED_MSB`+1, increments every clk edge regardless of lock, wraps to 0.
  - Blink index = cnt[LED_MSB-1:LED_MSB-3]; `idle` is high when the index is 3 or 5 (double blink).
  - Ramp = cnt[LED_MSB] ? cnt[LED_MSB-1:LED_MSB-5] : 31 − cnt[LED_MSB-1:LED_MSB-5], 5-bit.
  - `busy` = (cnt[LED_MSB-6:LED_MSB-10] ≥ ramp).
- LED selection, before the polarity option:
  - RESET_HOLD or BOOT: 0.
  - `dfu_state` 0x00: ~`idle`.
  - `dfu_state` 0x02: `idle`.
  - Any other `dfu_state`: `busy`.
  - The result is registered, then XORed with `LED_ACTIVE_LOW`.

## Timing
- Values during reset:
  - `core_reset`=1, `boot`=0, `bootloader_active`=0, `boot_sel`=`BOOT_IMAGE`.
  - `led`=`LED_ACTIVE_LOW` (LED off), LED counter=0.
- With `clk_locked` high from reset release:
  - `core_reset` falls after exactly `RESET_CYCLES` rising edges.
  - If nothing else happens, `boot` rises exactly `BOOT_CYCLES` edges after that.
- `clk_locked` low freezes both timers and holds the state; counting resumes with the value intact.
- Input-to-output latency is 1 cycle: from a qualifying `dfu_state`/`usb_reset`/`boot_req` sample to the `boot` or `bootloader_active` change.
- LED: 1 cycle from the counter/state to `led`.

## Test plan
- RESET_CYCLES=4, BOOT_CYCLES=10, locked, `dfu_state`=0 -> `core_reset` low after edge 4; `boot`=1 after edge 14 and held; `led`=0 before edge 4.
- Same params, `clk_locked` low for 5 cycles at edge 2 -> `core_reset` falls after edge 9, `boot` rises after edge 19.
- `dfu_state`=0x02 at WAIT_ENUM edge 3, then `dfu_state`=0x00 -> `bootloader_active`=1 permanently, `boot` stays 0 past 100 cycles.
- `dfu_state`≠0 on the same edge the timer hits 0 -> STAY, `boot`=0.
- In STAY, `dfu_state`=0x01 plus a one-cycle `usb_reset` -> `boot`=1 next edge; `usb_reset` with `dfu_state`=0x02 -> no change. `boot_req` in STAY -> `boot`=1; `reset_n` pulse afterwards -> `boot`=0, `core_reset`=1.
- LED_MSB=10, LED_ACTIVE_LOW=0, `dfu_state`=0x02 -> `led` high exactly for counter index 3 and 5 (cnt[9:7]), i.e. 256 of every 1024 cycles; `dfu_state`=0x05 -> duty varies with ramp, `led`=1 every cycle when ramp=0.
